// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone bus constants, request bundle type and index-width helper
package wb_pkg;

    localparam int WB_DW_DEF  = 32;
    localparam int WB_AW_DEF  = 30;
    localparam int WB_DW_MAX  = 64;
    localparam int WB_AW_MAX  = 64;
    localparam int WB_SEL_MAX = WB_DW_MAX / 8;

    typedef struct packed {
        logic                  we;
        logic [WB_AW_MAX-1:0]  addr;
        logic [WB_DW_MAX-1:0]  data;
        logic [WB_SEL_MAX-1:0] sel;
    } wb_req_t;

    // Width of a storage index for a given depth, never narrower than one bit
    function automatic int idx_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// wb_resp_pipe: LAT-deep valid/we/err/data response pipeline; dropping i_cyc discards everything in flight
module wb_resp_pipe #(
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cyc,
    input  logic          i_push,
    input  logic          i_we,
    input  logic          i_err,
    input  logic [DW-1:0] i_data,
    output logic          o_ack,
    output logic          o_err,
    output logic [DW-1:0] o_data
);

    logic [LAT-1:0]    v_q, we_q, err_q, v_d, we_d, err_d;
    logic [LAT*DW-1:0] data_q, data_d;

    // Shift one stage per cycle; a low i_cyc flushes every stage
    always_comb begin
        v_d    = i_cyc ? LAT'({v_q, i_push}) : '0;
        we_d   = LAT'({we_q, i_we});
        err_d  = LAT'({err_q, i_err});
        data_d = (LAT*DW)'({data_q, i_data});
    end

    // Pipeline registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q    <= '0;
            we_q   <= '0;
            err_q  <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            we_q   <= we_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    // Responses surface only while the bus cycle is still open
    assign o_ack  = i_cyc & v_q[LAT-1] & ~err_q[LAT-1];
    assign o_err  = i_cyc & v_q[LAT-1] & err_q[LAT-1];
    assign o_data = (o_ack & ~we_q[LAT-1]) ? data_q[LAT*DW-1 -: DW] : '0;

endmodule

// File: rtl/wb_reg_slave.sv
// wb_reg_slave: pipelined Wishbone B4 register-file slave with byte lanes and LAT-cycle ack.
// Define WB_REG_SLAVE_ADDR_ERR_EN to answer out-of-range addresses with o_wb_err instead of aliasing.
module wb_reg_slave
    import wb_pkg::*;
#(
    parameter int DW    = WB_DW_DEF,
    parameter int AW    = WB_AW_DEF,
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic [7:0]      o_leds
);

    localparam int IW = idx_w(DEPTH);
    localparam int NB = DW / 8;

    logic          stall_q;
    logic [7:0]    leds_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_d;
    logic [IW-1:0] idx;
    logic          accept, addr_err;

    assign idx    = i_wb_addr[IW-1:0];
    assign accept = i_wb_cyc & i_wb_stb & ~stall_q;
    assign rd_d   = mem_q[idx];

`ifdef WB_REG_SLAVE_ADDR_ERR_EN
    assign addr_err = i_wb_addr >= AW'(DEPTH);
`else
    logic unused_addr;
    assign unused_addr = ^i_wb_addr;
    assign addr_err    = 1'b0;
`endif

    // Stall for the single cycle after reset release; latch last accepted op on the LEDs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= 1'b1;
            leds_q  <= '0;
        end else begin
            stall_q <= 1'b0;
            if (accept) leds_q <= {i_wb_we, 7'(i_wb_addr)};
        end
    end

    // Storage: word i resets to i; accepted writes commit immediately, per enabled byte lane
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i);
        end else if (accept && i_wb_we && !addr_err) begin
            for (int b = 0; b < NB; b++)
                if (i_wb_sel[b]) mem_q[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
        end
    end

    wb_resp_pipe #(.DW(DW), .LAT(LAT)) u_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_cyc   (i_wb_cyc),
        .i_push  (accept),
        .i_we    (i_wb_we),
        .i_err   (addr_err),
        .i_data  (rd_d),
        .o_ack   (o_wb_ack),
        .o_err   (o_wb_err),
        .o_data  (o_wb_data)
    );

    assign o_wb_stall = stall_q;
    assign o_leds     = leds_q;

endmodule

// File: doc/wb_reg_slave.md
WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data bus width (multiple of 8, 8..64).
REQ-002 SHALL have parameter AW, default 30, meaning word address width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of DW-bit storage words (power of 2, 2..256).
REQ-004 SHALL have parameter LAT, default 1, meaning ack latency in cycles (1..4).
REQ-005 SHALL have ports, one per line, name direction width meaning:
  i_clk  in  1  single clock, all logic rising-edge.
  i_rst_n  in  1  asynchronous active-low reset.
  i_wb_cyc  in  1  bus cycle in progress.
  i_wb_stb  in  1  transfer request.
  i_wb_we  in  1  1=write, 0=read.
  i_wb_addr  in  AW  word address.
  i_wb_data  in  DW  write data.
  i_wb_sel  in  DW/8  byte-lane enables.
  o_wb_stall  out  1  slave cannot accept request.
  o_wb_ack  out  1  transfer completed OK.
  o_wb_err  out  1  transfer completed with error.
  o_wb_data  out  DW  read data, valid with o_wb_ack.
  o_leds  out  8  [7] last op was write, [6:0] last accepted address LSBs.

Function
REQ-006 SHALL accept a request in any cycle with i_wb_cyc & i_wb_stb & !o_wb_stall (pipelined Wishbone B4).
REQ-007 SHALL hold o_wb_stall low except the cycle immediately after reset release, where it is high for exactly one cycle.
REQ-008 SHALL issue exactly one o_wb_ack or o_wb_err per accepted request, LAT cycles after acceptance, in acceptance order; back-to-back requests yield back-to-back acks.
REQ-009 SHALL on accepted write update only byte lanes whose i_wb_sel bit is 1; i_wb_sel = 0 still acks and changes nothing.
REQ-010 SHALL return the word at the addressed index on read, all lanes regardless of i_wb_sel; o_wb_data is 0 in cycles without o_wb_ack.
REQ-011 SHALL return new data on a read accepted the cycle after a write to the same address (write-first, no hazard).
REQ-012 SHALL index storage with i_wb_addr[log2(DEPTH)-1:0].
REQ-013 SHALL track in-flight requests in a LAT-deep valid/we/err shift pipeline; when i_wb_cyc drops, all in-flight responses are discarded, with no ack/err, while writes already accepted still commit.
REQ-014 SHALL never assert o_wb_ack and o_wb_err in the same cycle.
REQ-015 SHALL update o_leds on every accepted request.

Reset
REQ-016 SHALL on i_rst_n low, asynchronously: o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_leds=0, o_wb_stall=1, pipeline cleared.
REQ-017 SHALL initialise storage word i to value i, zero-extended, on reset.
REQ-018 SHALL discard all in-flight transactions when reset asserts mid-operation, with no ack/err after release.

Configuration
REQ-019 SHALL with macro WB_REG_SLAVE_ADDR_ERR_EN defined respond o_wb_err, not ack, to any request with i_wb_addr >= DEPTH, without writing storage; o_wb_data=0.
REQ-020 SHALL without WB_REG_SLAVE_ADDR_ERR_EN alias addresses modulo DEPTH, and tie o_wb_err to 0.

Structure
REQ-021 SHALL take from shared package wb_pkg the WB bus width constants, a wb_req_t struct (we, addr, data, sel) and a function clog2-based index-width helper.
REQ-022 SHALL implement the LAT-deep response pipeline as sub-module wb_resp_pipe; storage and decode stay in wb_reg_slave.

Verification
REQ-023 Reset release: cycle 1 stall=1, cycle 2 stall=0; read addr 5 -> ack after LAT, o_wb_data=0x00000005.
REQ-024 Write addr 3 data 0xDEADBEEF sel=4'b0101, then read 3 -> 0x00AD00EF (reset value 3 in lane 0 overwritten).
REQ-025 Eight back-to-back reads addr 0..7, LAT=3 -> eight consecutive acks starting 3 cycles after first, data 0..7 in order.
REQ-026 Issue 2 writes with LAT=2, drop i_wb_cyc after 1 cycle -> zero acks; later reads show both writes committed.
REQ-027 With WB_REG_SLAVE_ADDR_ERR_EN, DEPTH=16: write addr 16 -> o_wb_err, no ack, word 0 unchanged; without macro: write addr 16 data 0x55 -> ack, read 0 -> 0x55.
REQ-028 Assert i_rst_n low with 2 requests in flight -> no ack/err after release, o_leds=0.
